// File: rtl/accum_bank.sv
// Multi-channel accumulator: each rising edge of Go applies add/sub/load/clear to channel Sel.
// Build option ACCUM_SATURATE_EN: add/subtract clamp at the range limits instead of wrapping.
module accum_bank #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 10,
   parameter int NUM_CH = 4,
   localparam int SEL_W = $clog2(NUM_CH)
) (
   input  logic              CLOCK_50,
   input  logic              Reset,
   input  logic              Go,
   input  logic [1:0]        Mode,
   input  logic [SEL_W-1:0]  Sel,
   input  logic [DATA_W-1:0] Data,
   output logic [ACC_W-1:0]  Acc_Out,
   output logic              Ovf,
   output logic              Done
);

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_LOAD = 2'b10,
      OP_CLR  = 2'b11
   } op_t;

   logic             g1, g2, g3;
   logic             strobe;
   op_t              op;
   logic [ACC_W-1:0] acc [NUM_CH];
   logic [NUM_CH-1:0] ovf;
   logic [ACC_W-1:0] data_ext;
   logic [ACC_W:0]   sum;
   logic [ACC_W:0]   diff;
   logic [ACC_W-1:0] nxt_acc;
   logic             nxt_ovf;

   assign strobe   = g2 & ~g3;
   assign op       = op_t'(Mode);
   assign data_ext = ACC_W'(Data);

   // MSB of the widened result is the carry (add) or borrow (sub).
   assign sum  = {1'b0, acc[Sel]} + {1'b0, data_ext};
   assign diff = {1'b0, acc[Sel]} - {1'b0, data_ext};

   always_comb begin
      nxt_acc = acc[Sel];
      nxt_ovf = ovf[Sel];
      case (op)
         OP_ADD: begin
            nxt_acc = sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
               nxt_ovf = 1'b1;
`ifdef ACCUM_SATURATE_EN
               nxt_acc = '1;
`endif
            end
         end
         OP_SUB: begin
            nxt_acc = diff[ACC_W-1:0];
            if (diff[ACC_W]) begin
               nxt_ovf = 1'b1;
`ifdef ACCUM_SATURATE_EN
               nxt_acc = '0;
`endif
            end
         end
         OP_LOAD: begin
            nxt_acc = data_ext;
            nxt_ovf = 1'b0;
         end
         OP_CLR: begin
            nxt_acc = '0;
            nxt_ovf = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         g1      <= 1'b0;
         g2      <= 1'b0;
         g3      <= 1'b0;
         acc     <= '{default: '0};
         ovf     <= '0;
         Acc_Out <= '0;
         Ovf     <= 1'b0;
         Done    <= 1'b0;
      end else begin
         g1 <= Go;
         g2 <= g1;
         g3 <= g2;
         if (strobe) begin
            acc[Sel] <= nxt_acc;
            ovf[Sel] <= nxt_ovf;
         end
         // Read path samples the pre-update register, so a write shows one edge later.
         Acc_Out <= acc[Sel];
         Ovf     <= ovf[Sel];
         Done    <= strobe;
      end
   end

endmodule
